// File: rtl/twiddle_mult_pipe.sv
// Pipelined complex multiply by W_N^k (or its conjugate) with rounding, saturation and a
// valid/ready handshake. Three register stages: operand/ROM, products, combine/round/saturate.
module twiddle_mult_pipe #(
    parameter int unsigned DW   = 16,
    parameter int unsigned CW   = 16,
    parameter int unsigned N    = 64,
    parameter int unsigned LOGN = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*DW-1:0]   in_data,
    input  logic [LOGN-1:0]   in_k,
    input  logic              in_inv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*DW-1:0]   out_data,
    output logic              sat_flag,
    input  logic              sat_clr
);

    localparam int unsigned PW = DW + CW;
    localparam int unsigned SW = PW + 1;
    localparam real Pi = 3.14159265358979323846;
    localparam logic signed [SW-1:0] RndBias = SW'(1) << (CW - 3);
    localparam logic signed [SW-1:0] SatMax  = SW'((2 ** (DW - 1)) - 1);
    localparam logic signed [SW-1:0] SatMin  = ~SatMax;

    // Coefficient ROM, rounded to nearest (ties away from zero) at elaboration.
    logic signed [CW-1:0] rom_c [N];
    logic signed [CW-1:0] rom_s [N];

    for (genvar g = 0; g < N; g++) begin : g_rom
        localparam real Ang = 2.0 * Pi * g / N;
        localparam real Cr  = (2.0 ** (CW - 2)) * $cos(Ang);
        localparam real Sr  = (2.0 ** (CW - 2)) * $sin(Ang);
        localparam int  Ci  = (Cr >= 0.0) ? $rtoi(Cr + 0.5) : -$rtoi(0.5 - Cr);
        localparam int  Si  = (Sr >= 0.0) ? $rtoi(Sr + 0.5) : -$rtoi(0.5 - Sr);
        assign rom_c[g] = CW'(Ci);
        assign rom_s[g] = CW'(Si);
    end

    logic advance;
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    // Stage 1: operands and coefficients
    logic                 s1_valid_q, s1_inv_q;
    logic signed [DW-1:0] s1_ar_q, s1_ai_q;
    logic signed [CW-1:0] s1_c_q, s1_s_q;

    // Stage 2: partial products
    logic                 s2_valid_q, s2_inv_q;
    logic signed [PW-1:0] s2_arc_q, s2_ais_q, s2_aic_q, s2_ars_q;

    logic signed [PW-1:0] ar_x, ai_x, c_x, s_x;
    assign ar_x = {{CW{s1_ar_q[DW-1]}}, s1_ar_q};
    assign ai_x = {{CW{s1_ai_q[DW-1]}}, s1_ai_q};
    assign c_x  = {{DW{s1_c_q[CW-1]}}, s1_c_q};
    assign s_x  = {{DW{s1_s_q[CW-1]}}, s1_s_q};

    function automatic logic [DW:0] round_sat(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] r;
        r = v + RndBias;
        r = r >>> (CW - 2);
        if (r > SatMax) begin
            return {1'b1, SatMax[DW-1:0]};
        end else if (r < SatMin) begin
            return {1'b1, SatMin[DW-1:0]};
        end
        return {1'b0, r[DW-1:0]};
    endfunction

    logic signed [SW-1:0] arc, ais, aic, ars, re_sum, im_sum;
    logic        [DW:0]   re_rs, im_rs;
    logic                 sat_now;

    always_comb begin
        arc    = {s2_arc_q[PW-1], s2_arc_q};
        ais    = {s2_ais_q[PW-1], s2_ais_q};
        aic    = {s2_aic_q[PW-1], s2_aic_q};
        ars    = {s2_ars_q[PW-1], s2_ars_q};
        re_sum = s2_inv_q ? (arc - ais) : (arc + ais);
        im_sum = s2_inv_q ? (aic + ars) : (aic - ars);
        re_rs  = round_sat(re_sum);
        im_rs  = round_sat(im_sum);
        sat_now = s2_valid_q & (re_rs[DW] | im_rs[DW]);
    end

    // Datapath registers carry no reset; stale contents are masked by the valids.
    always_ff @(posedge clk) begin
        if (advance) begin
            s1_ar_q  <= in_data[2*DW-1:DW];
            s1_ai_q  <= in_data[DW-1:0];
            s1_inv_q <= in_inv;
            s1_c_q   <= rom_c[in_k];
            s1_s_q   <= rom_s[in_k];
            s2_inv_q <= s1_inv_q;
            s2_arc_q <= ar_x * c_x;
            s2_ais_q <= ai_x * s_x;
            s2_aic_q <= ai_x * c_x;
            s2_ars_q <= ar_x * s_x;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            sat_flag   <= 1'b0;
        end else begin
            if (advance) begin
                s1_valid_q <= in_valid;
                s2_valid_q <= s1_valid_q;
                out_valid  <= s2_valid_q;
                out_data   <= {re_rs[DW-1:0], im_rs[DW-1:0]};
            end
            if (advance && sat_now) begin
                sat_flag <= 1'b1;
            end else if (sat_clr) begin
                sat_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_twiddle_mult_pipe.sv
// Randomised and directed bench for twiddle_mult_pipe against an arithmetic reference model.
module tb_twiddle_mult_pipe;

    localparam int DW = 16, CW = 16, N = 64, LOGN = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, in_valid, in_ready, in_inv, out_valid, out_ready, sat_flag, sat_clr;
    logic [2*DW-1:0] in_data, out_data;
    logic [LOGN-1:0] in_k;

    twiddle_mult_pipe #(.DW(DW), .CW(CW), .N(N), .LOGN(LOGN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_k     (in_k),
        .in_inv   (in_inv),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .sat_flag (sat_flag),
        .sat_clr  (sat_clr)
    );

    int checks = 0;
    int errs   = 0;
    logic [32:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint rnd(input real x);
        if (x >= 0.0) return longint'($rtoi(x + 0.5));
        return -longint'($rtoi(0.5 - x));
    endfunction

    function automatic logic [16:0] sat16(input longint v);
        if (v > 32767) return {1'b1, 16'h7FFF};
        if (v < -32768) return {1'b1, 16'h8000};
        return {1'b0, v[15:0]};
    endfunction

    // Reference: (a + jb) * (c -/+ js) with Q2.14 coefficients, round half up, saturate.
    function automatic logic [32:0] model(input logic [31:0] d, input int k, input logic inv);
        longint ar, ai, c, s, re, im;
        logic [16:0] rr, ri;
        ar = longint'(signed'(d[31:16]));
        ai = longint'(signed'(d[15:0]));
        c  = rnd(16384.0 * $cos(2.0 * 3.14159265358979 * k / 64.0));
        s  = rnd(16384.0 * $sin(2.0 * 3.14159265358979 * k / 64.0));
        re = inv ? (ar * c - ai * s) : (ar * c + ai * s);
        im = inv ? (ai * c + ar * s) : (ai * c - ar * s);
        rr = sat16((re + 8192) >>> 14);
        ri = sat16((im + 8192) >>> 14);
        return {rr[16] | ri[16], rr[15:0], ri[15:0]};
    endfunction

    // Scoreboard and handshake checks, sampled mid-cycle.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", 64'(out_data), 64'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL spurious_out: got %0h expected no output at %0t",
                             out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 64'(out_data), 64'(e[31:0]));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_data, int'(in_k), in_inv));
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic send(input logic [31:0] d, input int k, input logic inv,
                        input logic [31:0] exp, input string name);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_k     = LOGN'(k);
        in_inv   = inv;
        @(posedge clk);
        n = 1;
        #1 in_valid = 1'b0;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_latency"}, 64'(n), 64'd3);
        chk(name, 64'(out_data), 64'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, iter;
        logic fire;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_k = '0; in_inv = 1'b0;
        out_ready = 1'b1; sat_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_sat_flag", 64'(sat_flag), 64'd0);
        rst_n = 1'b1;

        send(32'h4000_2000, 0, 1'b0, 32'h4000_2000, "k0");
        chk("k0_sat_flag", 64'(sat_flag), 64'd0);
        send(32'h4000_2000, 16, 1'b0, 32'h2000_C000, "k16_fwd");
        send(32'h4000_2000, 16, 1'b1, 32'hE000_4000, "k16_inv");
        send(32'h4000_0000, 8, 1'b0, 32'h2D41_D2BF, "k8_fwd");
        send(32'h8000_1234, 16, 1'b0, 32'h1234_7FFF, "k16_neg_sat");
        chk("sat_set_k16", 64'(sat_flag), 64'd1);
        sat_clr = 1'b1;
        @(posedge clk);
        #1 sat_clr = 1'b0;
        chk("sat_clr_k16", 64'(sat_flag), 64'd0);
        send(32'h7FFF_7FFF, 8, 1'b0, 32'h7FFF_0000, "k8_sat");
        chk("sat_set", 64'(sat_flag), 64'd1);
        sat_clr = 1'b1;
        @(posedge clk);
        #1 sat_clr = 1'b0;
        chk("sat_clr", 64'(sat_flag), 64'd0);

        // Random stream with random backpressure; inputs held until accepted.
        sent = 0;
        iter = 0;
        while (sent < 200 && iter < 5000) begin
            @(negedge clk);
            fire = in_valid && in_ready;
            if (fire) sent++;
            @(posedge clk);
            #1;
            iter++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (fire || !in_valid) begin
                if (sent < 200 && $urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    in_data  = $urandom;
                    in_k     = LOGN'($urandom_range(0, N - 1));
                    in_inv   = 1'($urandom_range(0, 1));
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("stream_sent", 64'(sent), 64'd200);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain", 64'(exp_q.size()), 64'd0);

        // Reset with three samples in flight: none may ever emerge.
        in_valid = 1'b1;
        in_k = LOGN'(5); in_inv = 1'b0;
        in_data = 32'h1111_2222;
        @(posedge clk);
        #1 in_data = 32'h3333_4444;
        @(posedge clk);
        #1 in_data = 32'h5555_6666;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        chk("inflight_rst_valid", 64'(out_valid), 64'd0);
        chk("inflight_rst_sat", 64'(sat_flag), 64'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("no_stale", 64'(out_valid), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end

endmodule
